sha256_sched_ctrl: RTL and testbench
====================================

Name: sha256_sched_ctrl

Overview:
- Sequencer for the SHA-256 message-schedule shift pipeline.
- Accepts one 512-bit chunk as 16 big-endian 32-bit words over a valid/ready stream.
- Shifts the words into the schedule pipeline, then runs 64 expansion/round cycles, one per round.
- Publishes the round index (and optionally K[t]) to the compression core, then signals chunk completion.

Parameters:
- ROUNDS, 64, number of round cycles per chunk (fixed 64 for SHA-256; counter width 6).
- WORDS, 16, words loaded per chunk.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input word valid
- s_ready  out  1  controller accepts word this cycle
- s_data  in  32  input message word, MSB-first
- s_first  in  1  sampled with the first word of a chunk; marks first chunk of a message
- abort  in  1  synchronous flush to IDLE
- round_hold  in  1  stall request from compression core
- sched_load  out  1  load strobe to schedule pipeline (data-valid input)
- sched_din  out  32  word to schedule pipeline
- sched_run  out  1  expansion-advance strobe to schedule pipeline (process-start input)
- round_valid  out  1  current round t is presented this cycle
- round_idx  out  6  round index t, 0..63
- k_out  out  32  round constant K[t] (see Optional Feature)
- msg_first  out  1  latched s_first for the chunk in flight
- chunk_done  out  1  one-cycle pulse after round 63
- busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, word_cnt=0, round_idx=0, msg_first=0; all outputs 0 except s_ready=1 (combinational from IDLE).
- States:
  - IDLE: s_ready=1. On the first accept, latch s_first into msg_first, set word_cnt=1, go to LOAD.
  - LOAD: s_ready=1. Each accept increments word_cnt. When the accepted word is the 16th (word_cnt==15 at accept), go to ROUND with round_idx=0.
  - ROUND:
    - s_ready=0.
    - If round_hold=0: sched_run=1, round_valid=1, round_idx advances next cycle.
    - If round_hold=1: sched_run=0, round_valid=0, round_idx holds.
    - Non-held cycle with round_idx==63: go to DONE.
  - DONE: chunk_done=1 for exactly one cycle, s_ready=0, then go to IDLE. msg_first is held through DONE and cleared in IDLE.
- Accept = s_valid & s_ready. sched_load = accept (combinational). sched_din = s_data (combinational passthrough). No load without accept; s_valid without s_ready has no effect.
- Word order: the word accepted first is W0. During round t, the schedule pipeline head holds W_t.
- Latency (no stalls, s_valid continuously high):
  - Words accepted in cycles 0..15.
  - round_valid in cycles 16..79, round_idx = cycle−16.
  - chunk_done in cycle 80; s_ready in cycle 81.
- sched_load and sched_run are never asserted in the same cycle.
- round_hold outside ROUND is ignored.
- abort:
  - Highest priority. Any state goes to IDLE at the next edge; word_cnt and round_idx are cleared, msg_first cleared.
  - No chunk_done is generated.
  - The pipeline contents are not cleared; the next chunk fully overwrites them.
  - abort in the same cycle as an accept: the word is still forwarded (sched_load=1) but is discarded by the count clear.
- Asynchronous reset mid-chunk returns to reset values immediately; no partial outputs after release.
- Counters never wrap within a chunk; round_idx returns to 0 only via LOAD→ROUND or abort/reset.

Optional Feature:
- Macro: SHA256_SCHED_K_ROM_EN.
- Defined: internal 64x32 constant ROM; k_out = K[round_idx] combinationally, valid whenever round_valid=1 (K[0]=0x428a2f98, K[63]=0xc67178f2).
- Not defined: no ROM; k_out tied to 32'h0; compression core indexes its own ROM with round_idx.

Test Plan:
- "abc" chunk:
  - Stimulus: words 0x61626380, 14×0x00000000, 0x00000018, s_valid constant, s_first=1.
  - Required: s_ready low from cycle 16; round_valid in cycles 16..79; pipeline head = 0x61626380 at t=0, 0x000F0000 at t=17; k_out 0x428a2f98 at t=0 and 0xc67178f2 at t=63 (macro on); chunk_done pulse at cycle 80; msg_first=1 through 80.
- Gapped input: s_valid toggled 1/0 each cycle.
  - Required: exactly 16 sched_load pulses; ROUND entered the cycle after the 16th accept; no load while s_valid=0.
- Stall: round_hold=1 for 5 cycles at t=10.
  - Required: round_idx holds 10, sched_run=0 and round_valid=0 for 5 cycles; total ROUND duration 69 cycles; chunk_done after t=63.
- Abort at t=30.
  - Required: next cycle IDLE, s_ready=1, no chunk_done; a following full chunk completes with round_idx 0..63.
- Async reset asserted during LOAD with word_cnt=7.
  - Required: all outputs to reset values immediately; after release, a full 16-word chunk completes normally.
- Macro off build.
  - Required: k_out=0 throughout; all other timing identical to the "abc" scenario.

Source files
------------

// File: rtl/sha256_sched_ctrl.sv
// sha256_sched_ctrl
//   Sequencer for the SHA-256 message-schedule shift pipeline. It takes one
//   512-bit chunk as 16 big-endian words (W0 first) over a valid/ready
//   stream and forwards each accepted word to the schedule pipeline. It then
//   runs 64 round cycles that advance the expansion and present the round
//   index, and finally pulses chunk_done.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready       input word handshake; s_data is the word
//   s_first               sampled with the first word of a chunk
//   abort                 synchronous flush to IDLE, highest priority
//   round_hold            stall request from the compression core
//   sched_load/sched_din  load strobe and word to the schedule pipeline
//   sched_run             expansion-advance strobe to the schedule pipeline
//   round_valid/round_idx current round t (0..63)
//   k_out                 round constant K[t]
//   msg_first             s_first latched for the chunk in flight
//   chunk_done            one-cycle pulse after round 63
//   busy                  controller not idle
//
// Build option
//   SHA256_SCHED_K_ROM_EN  when defined, k_out = K[round_idx] from an
//                          internal ROM; otherwise k_out is tied to zero.
//
// state | meaning
// IDLE  | waiting for the first word of a chunk
// LOAD  | accepting words 2..16
// ROUND | one expansion/round per non-held cycle, t = 0..63
// DONE  | chunk_done pulse, then back to IDLE

module sha256_sched_ctrl #(
  parameter int ROUNDS = 64,
  parameter int WORDS  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_first,
  input  logic        abort,
  input  logic        round_hold,
  output logic        sched_load,
  output logic [31:0] sched_din,
  output logic        sched_run,
  output logic        round_valid,
  output logic [5:0]  round_idx,
  output logic [31:0] k_out,
  output logic        msg_first,
  output logic        chunk_done,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_WORD  = 4'(WORDS - 1);
  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  state_t      state, state_nxt;
  logic [3:0]  word_cnt, word_cnt_nxt;
  logic [5:0]  round_idx_nxt;
  logic        msg_first_nxt;
  logic        accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word_cnt  <= 4'd0;
      round_idx <= 6'd0;
      msg_first <= 1'b0;
    end else begin
      state     <= state_nxt;
      word_cnt  <= word_cnt_nxt;
      round_idx <= round_idx_nxt;
      msg_first <= msg_first_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    word_cnt_nxt  = word_cnt;
    round_idx_nxt = round_idx;
    msg_first_nxt = msg_first;
    s_ready       = 1'b0;
    sched_run     = 1'b0;
    round_valid   = 1'b0;
    chunk_done    = 1'b0;
    busy          = (state != IDLE);

    case (state)
      IDLE, LOAD: s_ready = 1'b1;
      ROUND: begin
        sched_run   = ~round_hold;
        round_valid = ~round_hold;
      end
      DONE: chunk_done = 1'b1;
      default: ;
    endcase

    accept = s_valid & s_ready;

    case (state)
      IDLE: begin
        msg_first_nxt = 1'b0;
        if (accept) begin
          msg_first_nxt = s_first;
          word_cnt_nxt  = 4'd1;
          state_nxt     = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          if (word_cnt == LAST_WORD) begin
            word_cnt_nxt  = 4'd0;
            round_idx_nxt = 6'd0;
            state_nxt     = ROUND;
          end else begin
            word_cnt_nxt = word_cnt + 4'd1;
          end
        end
      end
      ROUND: begin
        if (!round_hold) begin
          // round_idx stays at 63 through DONE/IDLE; only a new chunk,
          // abort or reset bring it back to 0.
          if (round_idx == LAST_ROUND) state_nxt = DONE;
          else round_idx_nxt = round_idx + 6'd1;
        end
      end
      DONE: begin
        msg_first_nxt = 1'b0;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // A word accepted alongside abort is still forwarded below, but the
    // count clear discards it; the next chunk overwrites the pipeline.
    if (abort) begin
      state_nxt     = IDLE;
      word_cnt_nxt  = 4'd0;
      round_idx_nxt = 6'd0;
      msg_first_nxt = 1'b0;
    end
  end

  assign sched_load = accept;
  assign sched_din  = s_data;

`ifdef SHA256_SCHED_K_ROM_EN
  localparam logic [31:0] K_TAB [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  assign k_out = K_TAB[round_idx];
`else
  assign k_out = 32'h0;
`endif

endmodule

// File: tb/tb_sha256_sched_ctrl.sv
// Directed bench for sha256_sched_ctrl. Inputs change 1 ns after the rising
// edge; outputs are sampled 1 ns after the falling edge. A reference model of
// the schedule pipeline is fed from the observed load/run strobes so the head
// word at given rounds can be compared with hand-computed message words.

module tb_sha256_sched_ctrl;

  typedef logic [31:0] blk_t [16];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ready, s_first, abort, round_hold;
  logic [31:0] s_data, sched_din, k_out;
  logic        sched_load, sched_run, round_valid, msg_first, chunk_done, busy;
  logic [5:0]  round_idx;

  sha256_sched_ctrl dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_first(s_first), .abort(abort), .round_hold(round_hold),
    .sched_load(sched_load), .sched_din(sched_din), .sched_run(sched_run),
    .round_valid(round_valid), .round_idx(round_idx), .k_out(k_out),
    .msg_first(msg_first), .chunk_done(chunk_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  // pipeline model and per-run observations
  logic [31:0] pipe [16];
  int n_load, n_run, n_done, rv_cnt, first_rv, last_rv, done_c, ready_low;
  int overlap, load_nv, idx_err, held10, mf_low, kerr, probe_c;
  logic [31:0] head0, head17, k0, k63;
  logic ready_after, mf_after, mf_done, probe_ready, probe_busy;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic clear(input int probe);
    n_load = 0; n_run = 0; n_done = 0; rv_cnt = 0; first_rv = -1; last_rv = -1;
    done_c = -100; ready_low = -1; overlap = 0; load_nv = 0; idx_err = 0;
    held10 = 0; mf_low = 0; kerr = 0; probe_c = probe;
    head0 = 'x; head17 = 'x; k0 = 'x; k63 = 'x;
    ready_after = 'x; mf_after = 'x; mf_done = 'x; probe_ready = 'x; probe_busy = 'x;
  endtask

  task automatic mon(input int rel);
    logic [31:0] nw;
    if (sched_load && sched_run) overlap++;
    if (sched_load) begin
      n_load++;
      if (!s_valid) load_nv++;
      for (int i = 0; i < 15; i++) pipe[i] = pipe[i+1];
      pipe[15] = sched_din;
    end
    if (round_valid) begin
      if (rv_cnt == 0) first_rv = rel;
      last_rv = rel;
      if (round_idx != 6'(rv_cnt)) idx_err++;
      if (round_idx == 6'd0)  begin head0 = pipe[0]; k0 = k_out; end
      if (round_idx == 6'd17) head17 = pipe[0];
      if (round_idx == 6'd63) k63 = k_out;
      rv_cnt++;
    end
`ifndef SHA256_SCHED_K_ROM_EN
    if (k_out != 32'h0) kerr++;
`endif
    if (sched_run) begin
      n_run++;
      nw = sig1(pipe[14]) + pipe[9] + sig0(pipe[1]) + pipe[0];
      for (int i = 0; i < 15; i++) pipe[i] = pipe[i+1];
      pipe[15] = nw;
    end
    if (round_hold && busy && !round_valid && !chunk_done && round_idx == 6'd10) held10++;
    if (busy && !msg_first) mf_low++;
    if (!s_ready && ready_low < 0) ready_low = rel;
    if (n_done > 0 && rel == done_c + 1) begin ready_after = s_ready; mf_after = msg_first; end
    if (chunk_done) begin n_done++; done_c = rel; mf_done = msg_first; end
    if (rel == probe_c) begin probe_ready = s_ready; probe_busy = busy; end
  endtask

  task automatic tick(input int rel);
    @(negedge clk); #1;
    mon(rel);
    @(posedge clk); #1;
  endtask

  task automatic run_chunk(input blk_t wd, input bit gap, input bit first,
                           input int hold_at, input int hold_len,
                           input int abort_at, input int ncyc, input int probe);
    int k;
    k = 0;
    clear(probe);
    for (int c = 0; c < ncyc; c++) begin
      s_valid = (k < 16) && (!gap || (c % 2 == 0));
      if (k < 16) s_data = wd[k];
      else        s_data = 32'h0;
      s_first    = first && (k == 0);
      round_hold = (c >= hold_at) && (c < hold_at + hold_len);
      abort      = (c == abort_at);
      if (s_valid) k++;
      tick(c);
    end
    s_valid = 0; s_first = 0; round_hold = 0; abort = 0; s_data = 0;
  endtask

  blk_t abc, alt;

  initial begin
    for (int i = 0; i < 16; i++) begin
      abc[i] = 32'h0;
      alt[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    end
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;
    rst_n = 0; s_valid = 0; s_data = 0; s_first = 0; abort = 0; round_hold = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(s_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_idx", 32'(round_idx), 0);
    rst_n = 1;
    @(posedge clk); #1;

    // abc chunk, no stalls
    run_chunk(abc, 0, 1, 1000, 0, 1000, 85, -1);
    chk("abc_loads", n_load, 16);
    chk("abc_ready_low", ready_low, 16);
    chk("abc_first_rv", first_rv, 16);
    chk("abc_last_rv", last_rv, 79);
    chk("abc_rounds", rv_cnt, 64);
    chk("abc_idx", idx_err, 0);
    chk("abc_head0", head0, 32'h61626380);
    chk("abc_head17", head17, 32'h000F0000);
`ifdef SHA256_SCHED_K_ROM_EN
    chk("abc_k0", k0, 32'h428a2f98);
    chk("abc_k63", k63, 32'hc67178f2);
`else
    chk("abc_k0", k0, 32'h0);
    chk("abc_k63", k63, 32'h0);
    chk("abc_k_zero", kerr, 0);
`endif
    chk("abc_done_cyc", done_c, 80);
    chk("abc_done_cnt", n_done, 1);
    chk("abc_mf_busy", mf_low, 0);
    chk("abc_mf_done", 32'(mf_done), 1);
    chk("abc_ready81", 32'(ready_after), 1);
    chk("abc_mf81", 32'(mf_after), 0);
    chk("abc_overlap", overlap, 0);

    // gapped input, s_first=0, round_hold asserted during LOAD (ignored)
    run_chunk(alt, 1, 0, 3, 10, 1000, 100, -1);
    chk("gap_loads", n_load, 16);
    chk("gap_load_nv", load_nv, 0);
    chk("gap_first_rv", first_rv, 31);
    chk("gap_done_cyc", done_c, 95);
    chk("gap_mf_done", 32'(mf_done), 0);
    chk("gap_overlap", overlap, 0);

    // stall of 5 cycles at t=10
    run_chunk(abc, 0, 1, 26, 5, 1000, 90, -1);
    chk("stall_held10", held10, 5);
    chk("stall_runs", n_run, 64);
    chk("stall_rounds", rv_cnt, 64);
    chk("stall_span", last_rv - first_rv + 1, 69);
    chk("stall_idx", idx_err, 0);
    chk("stall_done_cyc", done_c, 85);
    chk("stall_head17", head17, 32'h000F0000);

    // abort while round 30 is presented
    run_chunk(abc, 0, 1, 1000, 0, 46, 90, 47);
    chk("abort_rounds", rv_cnt, 31);
    chk("abort_ready", 32'(probe_ready), 1);
    chk("abort_busy", 32'(probe_busy), 0);
    chk("abort_no_done", n_done, 0);
    chk("abort_mf", 32'(msg_first), 0);
    run_chunk(abc, 0, 0, 1000, 0, 1000, 85, -1);
    chk("post_abort_rounds", rv_cnt, 64);
    chk("post_abort_idx", idx_err, 0);
    chk("post_abort_done", done_c, 80);
    chk("post_abort_head0", head0, 32'h61626380);

    // async reset during LOAD with word_cnt=7
    clear(-1);
    for (int c = 0; c < 7; c++) begin
      s_valid = 1; s_data = alt[c]; s_first = (c == 0);
      tick(c);
    end
    s_valid = 0; s_first = 0;
    chk("pre_rst_busy", 32'(busy), 1);
    rst_n = 0;
    #1;
    chk("arst_ready", 32'(s_ready), 1);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_mf", 32'(msg_first), 0);
    chk("arst_idx", 32'(round_idx), 0);
    chk("arst_outs", {29'h0, sched_run, round_valid, chunk_done}, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk); #1;
    run_chunk(abc, 0, 1, 1000, 0, 1000, 85, -1);
    chk("arst_loads", n_load, 16);
    chk("arst_rounds", rv_cnt, 64);
    chk("arst_first_rv", first_rv, 16);
    chk("arst_done_cyc", done_c, 80);
    chk("arst_head17", head17, 32'h000F0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
